// File: rtl/sequencer.sv
// rtl/sequencer.sv - control-unit FSM for the accumulator processor; optional SEQ_MEM_READY_EN adds mem_ready wait states
// Outputs are decoded combinationally from state, op and z_flag, and are forced low while reset is high.
module sequencer #(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            reset,
`ifdef SEQ_MEM_READY_EN
    input  logic            mem_ready,
`endif
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    typedef enum logic [3:0] {
        FETCH0 = 4'd0,
        FETCH1 = 4'd1,
        FETCH2 = 4'd2,
        DECODE = 4'd3,
        MEMRD  = 4'd4,
        EXEC   = 4'd5,
        STORE0 = 4'd6,
        STORE1 = 4'd7,
        BNE0   = 4'd8,
        XOR0   = 4'd9,
        HALT   = 4'd10
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_BNE   = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    state_t     state;
    state_t     next_state;
    logic [2:0] opc;
    logic       mem_go;

    assign opc = op[2:0];

`ifdef SEQ_MEM_READY_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH0;
        unique case (state)
            FETCH0: next_state = FETCH1;
            FETCH1: next_state = mem_go ? FETCH2 : FETCH1;
            FETCH2: next_state = DECODE;
            DECODE: begin
                unique case (opc)
                    OP_LOAD, OP_ADD, OP_SUB: next_state = MEMRD;
                    OP_STORE:                next_state = STORE0;
                    OP_BNE:                  next_state = BNE0;
                    OP_XOR:                  next_state = XOR0;
                    OP_HALT:                 next_state = HALT;
                    OP_NOP:                  next_state = FETCH0;
                    default:                 next_state = FETCH0;
                endcase
            end
            MEMRD:  next_state = mem_go ? EXEC : MEMRD;
            EXEC:   next_state = FETCH0;
            STORE0: next_state = STORE1;
            STORE1: next_state = mem_go ? FETCH0 : STORE1;
            BNE0:   next_state = FETCH0;
            XOR0:   next_state = FETCH0;
            HALT:   next_state = HALT;
            default: next_state = FETCH0;
        endcase
    end

    always_comb begin
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        ALU_ACC  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        ALU_xor  = 1'b0;
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        Addr_bus = 1'b0;
        load_IR  = 1'b0;
        load_MAR = 1'b0;
        MDR_bus  = 1'b0;
        load_MDR = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b0;
        halted   = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH0: begin
                    PC_bus   = 1'b1;
                    load_MAR = 1'b1;
                    load_PC  = 1'b1;
                    INC_PC   = 1'b1;
                end
                FETCH1: begin
                    CS   = 1'b1;
                    R_NW = 1'b1;
                end
                FETCH2: begin
                    MDR_bus = 1'b1;
                    load_IR = 1'b1;
                end
                DECODE: begin
                    Addr_bus = 1'b1;
                    load_MAR = 1'b1;
                end
                MEMRD: begin
                    CS   = 1'b1;
                    R_NW = 1'b1;
                end
                EXEC: begin
                    MDR_bus  = 1'b1;
                    load_ACC = 1'b1;
                    ALU_ACC  = (opc != OP_LOAD);
                    ALU_add  = (opc == OP_ADD);
                    ALU_sub  = (opc == OP_SUB);
                end
                STORE0: begin
                    ACC_bus  = 1'b1;
                    load_MDR = 1'b1;
                end
                STORE1: begin
                    CS = 1'b1;
                end
                BNE0: begin
                    // Branch taken when the accumulator is non-zero: PC loads the address field.
                    Addr_bus = !z_flag;
                    load_PC  = !z_flag;
                end
                XOR0: begin
                    load_ACC = 1'b1;
                    ALU_ACC  = 1'b1;
                    ALU_xor  = 1'b1;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Control-unit FSM for the basic accumulator processor, directly upstream of the ALU.
- Decodes the opcode held in the instruction register and drives the per-cycle strobes for the ALU, PC, IR, MAR, MDR and memory.
- Consumes the ALU's z_flag for conditional branching.
- One instruction takes a 3-state fetch, then decode/execute states.

Parameters:
- OP_W, 3, opcode width; the encodings below use the low 3 bits.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  OP_W  opcode field from the IR; stable from the DECODE state onward.
- z_flag  input  1  ALU accumulator-zero flag.
- ACC_bus  output  1  ALU drives sysbus with the accumulator.
- load_ACC  output  1  ALU accumulator load enable.
- ALU_ACC  output  1  accumulator takes an ALU result (0 = takes sysbus).
- ALU_add  output  1  add select.
- ALU_sub  output  1  subtract select.
- ALU_xor  output  1  xor select.
- PC_bus  output  1  PC drives sysbus.
- load_PC  output  1  PC load.
- INC_PC  output  1  PC increments (qualified by load_PC).
- Addr_bus  output  1  IR address field drives sysbus.
- load_IR  output  1  IR load.
- load_MAR  output  1  MAR load.
- MDR_bus  output  1  MDR drives sysbus.
- load_MDR  output  1  MDR load from sysbus.
- CS  output  1  memory chip select.
- R_NW  output  1  1 = read, 0 = write; qualified by CS.
- halted  output  1  high while in the HALT state.

Behaviour:
- The clock port is named clock. Reset is synchronous and active-high: when reset is sampled high at a rising edge of clock, state becomes FETCH0.
- While reset is high, all outputs are forced to 0 combinationally. After release, the first active state is FETCH0.
- Outputs are decoded from the current state, plus op, plus z_flag in BNE0. They are not registered: zero latency from state.
- At most one of ACC_bus, PC_bus, MDR_bus, Addr_bus is high in any cycle. Every unlisted output is 0.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 101 XOR, 110 HALT, 111 NOP.
- States, outputs and transitions:
  - FETCH0: PC_bus, load_MAR, load_PC, INC_PC -> FETCH1.
  - FETCH1: CS, R_NW -> FETCH2.
  - FETCH2: MDR_bus, load_IR -> DECODE.
  - DECODE: Addr_bus, load_MAR. Next state by op:
    - LOAD/ADD/SUB -> MEMRD.
    - STORE -> STORE0.
    - BNE -> BNE0.
    - XOR -> XOR0.
    - HALT -> HALT.
    - NOP -> FETCH0.
  - MEMRD: CS, R_NW -> EXEC.
  - EXEC: MDR_bus, load_ACC. ALU_ACC = (op != LOAD); ALU_add = (op == ADD); ALU_sub = (op == SUB). -> FETCH0.
  - STORE0: ACC_bus, load_MDR -> STORE1.
  - STORE1: CS, R_NW = 0 -> FETCH0.
  - BNE0: if z_flag == 0, assert Addr_bus and load_PC (INC_PC = 0). If z_flag == 1, no strobes. -> FETCH0 either way.
  - XOR0: load_ACC, ALU_ACC, ALU_xor -> FETCH0.
  - HALT: halted = 1, no other strobes. Remains in HALT until reset.
- Cycle counts per instruction:
  - LOAD/ADD/SUB/STORE: 6.
  - BNE/XOR: 5.
  - NOP: 4.
- ALU_add, ALU_sub and ALU_xor are mutually exclusive. Each is asserted only together with load_ACC and ALU_ACC.
- Encoding safety: any unreachable state encoding transitions to FETCH0 with all outputs 0.
- Reset mid-instruction (any state, including HALT): all outputs drop to 0 combinationally; FETCH0 on the next edge. No partial write is completed: CS is low while reset is high.

Optional Feature:
- Macro: SEQ_MEM_READY_EN.
- When defined:
  - Input port mem_ready (1 bit) is added.
  - FETCH1, MEMRD and STORE1 hold their state and their CS/R_NW values until mem_ready is sampled high, then advance on that edge.
  - mem_ready is ignored in all other states.
  - Reset overrides a pending wait.
- When undefined: the port is absent and memory states last exactly one cycle.

Test Plan:
- Reset release, then op = 000 (LOAD) -> sequence FETCH0, FETCH1, FETCH2, DECODE, MEMRD, EXEC. EXEC has MDR_bus = 1, load_ACC = 1, ALU_ACC = 0. PC_bus is high again in cycle 7.
- op = 011 (SUB) -> in cycle 6: load_ACC = 1, ALU_ACC = 1, ALU_sub = 1, ALU_add = 0, ALU_xor = 0.
- op = 001 (STORE) -> cycle 5: ACC_bus = 1, load_MDR = 1. Cycle 6: CS = 1, R_NW = 0.
- op = 100 (BNE):
  - z_flag = 0 -> cycle 5: Addr_bus = 1, load_PC = 1, INC_PC = 0.
  - z_flag = 1 -> cycle 5: all strobes 0.
  - Both cases: FETCH0 in cycle 6.
- op = 110 (HALT) -> halted = 1 from cycle 5, held for 20 cycles with no strobes. Assert reset for 1 cycle -> outputs 0 during reset; PC_bus = 1 on the first cycle after release.
- SEQ_MEM_READY_EN defined, mem_ready low for 3 cycles in FETCH1 -> CS = 1 and R_NW = 1 held for 4 cycles. FETCH2 follows the edge where mem_ready = 1.
